// File: rtl/imem_fetch_responder.sv
// Fetch responder: turns accepted PCs into instruction words through a fixed-latency
// memory pipeline, a credit-managed skid FIFO and the IF/ID output register.
module imem_fetch_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 1,
    parameter int    BUF_DEPTH   = 4,
    parameter string INIT_FILE   = "imem.hex"
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    PCF,
    input  logic                           req_valid,
    input  logic                           flush,
    input  logic                           StallD,
    input  logic                           imem_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] imem_waddr,
    input  logic [31:0]                    imem_wdata,
    output logic                           fetch_stall,
    output logic [31:0]                    InstrD,
    output logic [31:0]                    PCD,
    output logic [31:0]                    PCPlus4D,
    output logic                           ValidD,
    output logic                           FaultD
);
    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam int          PW  = $clog2(BUF_DEPTH);
    localparam int          CW  = $clog2(BUF_DEPTH + LATENCY + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          accept_s, acc_fault_s;
    logic [31:0]   acc_instr_s;
    logic          push_s, push_fault_s, pop_s;
    logic [31:0]   push_pc_s, push_instr_s;
    logic [CW-1:0] inflight_s;

    logic [31:0]   f_instr_q [BUF_DEPTH];
    logic [31:0]   f_pc_q    [BUF_DEPTH];
    logic          f_fault_q [BUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
    logic          valid_q, valid_d, fault_q, fault_d;

    // Loader port; the read below sees the pre-write contents in the same cycle.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem_q[imem_waddr] <= imem_wdata;
        end
    end

    // Request acceptance, word read and fault classification.
    always_comb begin
        accept_s    = req_valid && !fetch_stall && !flush;
        acc_fault_s = (PCF[1:0] != 2'b00) || ((PCF >> (AW + 2)) != 32'd0);
        acc_instr_s = acc_fault_s ? NOP : mem_q[PCF[AW+1:2]];
    end

    if (LATENCY == 1) begin : g_direct
        // Single-cycle read lands straight in the FIFO at the acceptance edge.
        always_comb begin
            push_s       = accept_s;
            push_pc_s    = PCF;
            push_instr_s = acc_instr_s;
            push_fault_s = acc_fault_s;
            inflight_s   = '0;
        end
    end else begin : g_pipe
        localparam int NS = LATENCY - 1;
        logic        pv_q [NS];
        logic        pf_q [NS];
        logic [31:0] ppc_q [NS];
        logic [31:0] pin_q [NS];

        // Delay stages carrying {valid, pc, fault, data}; flush kills every valid bit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < NS; i++) begin
                    pv_q[i]  <= 1'b0;
                    pf_q[i]  <= 1'b0;
                    ppc_q[i] <= 32'd0;
                    pin_q[i] <= NOP;
                end
            end else begin
                pv_q[0]  <= accept_s;
                pf_q[0]  <= acc_fault_s;
                ppc_q[0] <= PCF;
                pin_q[0] <= acc_instr_s;
                for (int i = 1; i < NS; i++) begin
                    pv_q[i]  <= pv_q[i-1] && !flush;
                    pf_q[i]  <= pf_q[i-1];
                    ppc_q[i] <= ppc_q[i-1];
                    pin_q[i] <= pin_q[i-1];
                end
            end
        end

        // Pipeline exit and count of valid entries still in flight.
        always_comb begin
            inflight_s = '0;
            for (int i = 0; i < NS; i++) begin
                inflight_s = inflight_s + CW'(pv_q[i]);
            end
            push_s       = pv_q[NS-1] && !flush;
            push_pc_s    = ppc_q[NS-1];
            push_instr_s = pin_q[NS-1];
            push_fault_s = pf_q[NS-1];
        end
    end

    assign fetch_stall = (count_q + inflight_s) >= CW'(BUF_DEPTH);

    // FIFO control next-state; a flush empties it outright.
    always_comb begin
        pop_s    = !flush && !StallD && (count_q != '0);
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            count_d  = count_d;
        end
    end

    // FIFO storage; contents are meaningless while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push_s) begin
            f_instr_q[wr_ptr_q] <= push_instr_s;
            f_pc_q[wr_ptr_q]    <= push_pc_s;
            f_fault_q[wr_ptr_q] <= push_fault_s;
        end
    end

    // IF/ID next-state: flush beats stall, stall holds everything.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!StallD) begin
            if (count_q != '0) begin
                instr_d = f_instr_q[rd_ptr_q];
                pc_d    = f_pc_q[rd_ptr_q];
                pc4_d   = f_pc_q[rd_ptr_q] + 32'd4;
                valid_d = 1'b1;
                fault_d = f_fault_q[rd_ptr_q];
            end else begin
                instr_d = NOP;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= NOP;
            pc_q     <= 32'd0;
            pc4_q    <= 32'd4;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pc_q;
    assign PCPlus4D = pc4_q;
    assign ValidD   = valid_q;
    assign FaultD   = fault_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_s && !pop_s && (count_q == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (LATENCY=1, BUF_DEPTH=4): a memory model and
// an expected-result queue predict every D-stage output and fetch_stall each cycle.
module tb_imem_fetch_responder;
    localparam int          BUF = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, req_valid, flush, stall_d, imem_we;
    logic [31:0] pcf, imem_wdata;
    logic [9:0]  imem_waddr;
    logic        fetch_stall, valid_d, fault_d;
    logic [31:0] instr_d, pc_d, pc4_d;

    exp_t        q[$];
    logic [31:0] mdl [1024];
    logic        m_valid, m_fault, acc_last;
    logic [31:0] m_instr, m_pc, next_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .DEPTH_WORDS(1024), .LATENCY(1), .BUF_DEPTH(BUF), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst), .PCF(pcf), .req_valid(req_valid), .flush(flush),
        .StallD(stall_d), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .fetch_stall(fetch_stall), .InstrD(instr_d),
        .PCD(pc_d), .PCPlus4D(pc4_d), .ValidD(valid_d), .FaultD(fault_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_instr = NOP;
        m_pc    = 32'd0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_InstrD"}, instr_d, NOP);
        chk({tag, "_PCD"}, pc_d, 32'd0);
        chk({tag, "_PCPlus4D"}, pc4_d, 32'd4);
        chk({tag, "_ValidD"}, {31'd0, valid_d}, 32'd0);
        chk({tag, "_FaultD"}, {31'd0, fault_d}, 32'd0);
        chk({tag, "_fetch_stall"}, {31'd0, fetch_stall}, 32'd0);
    endtask

    // One clock: predict acceptance, advance the model across the edge, compare outputs.
    task automatic cyc();
        int   avail;
        logic was_flush, was_upd;
        exp_t e;
        chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, logic'(q.size() >= BUF)});
        avail     = q.size();
        was_flush = flush;
        was_upd   = !stall_d;
        acc_last  = req_valid && (q.size() < BUF) && !flush;
        if (acc_last) begin
            e.pc    = pcf;
            e.fault = (pcf[1:0] != 2'b00) || (pcf >= 32'd4096);
            e.instr = e.fault ? NOP : mdl[pcf[11:2]];
            q.push_back(e);
        end
        @(posedge clk);
        if (imem_we) mdl[imem_waddr] = imem_wdata;
        if (was_flush) begin
            q.delete();
            m_valid = 1'b0;
            m_instr = NOP;
            m_fault = 1'b0;
        end else if (was_upd) begin
            if (avail > 0) begin
                e       = q.pop_front();
                m_valid = 1'b1;
                m_instr = e.instr;
                m_pc    = e.pc;
                m_fault = e.fault;
            end else begin
                m_valid = 1'b0;
                m_instr = NOP;
                m_fault = 1'b0;
            end
        end
        #1;
        chk("ValidD", {31'd0, valid_d}, {31'd0, m_valid});
        chk("InstrD", instr_d, m_instr);
        chk("PCD", pc_d, m_pc);
        chk("PCPlus4D", pc4_d, m_pc + 32'd4);
        chk("FaultD", {31'd0, fault_d}, {31'd0, m_fault});
    endtask

    task automatic stream(input int n, input logic stall);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b1;
            pcf       = next_pc;
            stall_d   = stall;
            cyc();
            if (acc_last) next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        stall_d   = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
    endtask

    task automatic request(input logic [31:0] pc);
        req_valid = 1'b1;
        pcf       = pc;
        cyc();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; stall_d = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; pcf = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        // Load words 0..63 with 0x100+w.
        for (int w = 0; w < 64; w++) begin
            imem_we    = 1'b1;
            imem_waddr = 10'(w);
            imem_wdata = 32'h100 + 32'(w);
            cyc();
        end
        imem_we = 1'b0;

        // Back-to-back sequential stream.
        next_pc = 32'd0;
        stream(8, 1'b0);
        drain();

        // Decode stall fills the credit window, then release.
        stream(4, 1'b0);
        stream(5, 1'b1);
        stream(6, 1'b0);
        drain();

        // Flush drops in-flight 0x10/0x14 and ignores the 0x40 of the flush cycle.
        stall_d = 1'b1;
        request(32'h10);
        request(32'h14);
        flush = 1'b1;
        request(32'h40);
        flush   = 1'b0;
        stall_d = 1'b0;
        request(32'h40);
        drain();

        // Misaligned and out-of-range fetches.
        request(32'h22);
        request(32'h1000);
        request(32'h8);
        drain();

        // Asynchronous reset with three entries queued.
        next_pc = 32'd0;
        stream(3, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_reset("midreset");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        next_pc = 32'd0;
        stream(8, 1'b0);
        drain();

        // Loader write racing a read of the same word returns the old word first.
        imem_we    = 1'b1;
        imem_waddr = 10'd5;
        imem_wdata = 32'hDEAD_BEEF;
        request(32'h14);
        imem_we = 1'b0;
        request(32'h14);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
